brq_ifu_dummy_burst: RTL and testbench
======================================

// Module: brq_ifu_dummy_burst
// PURPOSE
//  Next-generation dummy-instruction inserter for the IF stage. Inserts pseudo-random R-type ops
//  (rd=x0) after a masked random count of accepted real fetches, optionally as bursts of
//  1..MaxBurst back-to-back dummies. Supports 8 selectable op types and flush-aware abort.
//  Sits beside the IF/ID pipeline register and drives the IF dummy-select mux.
// PARAMETERS
//  CntW      5   width of the fetch counter and random threshold
//  MaskW     3   width of the CSR mask applied to the threshold's top bits (MaskW <= CntW)
//  MaxBurst  4   maximum dummies per burst; power of two, >= 1
//  LfsrW     32  prim_lfsr width; must be >= 13 + CntW + $clog2(MaxBurst)
// PORTS
//  clk_i                  in   1       clock
//  rst_ni                 in   1       reset, asynchronous, active-low
//  dummy_instr_en_i       in   1       CSR enable
//  dummy_instr_mask_i     in   MaskW   threshold mask (1s keep LFSR bits)
//  dummy_type_en_i        in   8       per-type enable; bit index = dummy_type_e
//  dummy_burst_en_i       in   1       allow bursts > 1
//  dummy_seed_en_i        in   1       reseed strobe
//  dummy_seed_i           in   32      seed contribution
//  fetch_valid_i          in   1       real instruction presented to ID
//  id_in_ready_i          in   1       ID accepts this cycle
//  flush_i                in   1       IF flush (branch/exception)
//  insert_dummy_instr_o   out  1       select dummy instead of fetched instruction
//  dummy_instr_data_o     out  32      dummy instruction encoding
// BEHAVIOUR
//  - Reset: state IDLE, cnt_q=0, burst_left_q=0, seed_q=0, insert_dummy_instr_o=0.
//    dummy_instr_data_o is combinational from LFSR state.
//  - LFSR fields, LSB first: cnt[CntW], op_a[5], op_b[5], type[3], burst[$clog2(MaxBurst)].
//  - threshold = lfsr.cnt & {mask_i, {CntW-MaskW{1'b1}}}.
//  - FSM IDLE/COUNT/INSERT. Any state with en_i=0 -> IDLE next cycle.
//    insert_dummy_instr_o = (state==INSERT) & en_i; output drops in the same cycle en_i falls.
//  - IDLE: en_i=1 -> COUNT with cnt_q=0.
//  - COUNT: a real accept (fetch_valid_i & id_in_ready_i & !insert) increments cnt_q.
//    An accept with cnt_q >= threshold -> INSERT, cnt_q<=0,
//    burst_left_q <= burst_en_i ? lfsr.burst+1 : 1.
//    Result: one window = exactly threshold+1 real instructions; >= covers a mask change mid-window.
//  - INSERT: when id_in_ready_i, the LFSR steps and burst_left_q decrements.
//    burst_left_q==1 at the handshake -> COUNT. Data holds stable while id_in_ready_i=0.
//  - flush_i has priority over id_in_ready_i. In INSERT it aborts the burst:
//    -> COUNT, cnt_q=0, LFSR steps once (no replay).
//    In COUNT it clears cnt_q.
//  - Seed: seed_q <= seed_q ^ seed_i; LFSR loaded with the new value.
//    Seed wins over an LFSR step in the same cycle. FSM is unaffected.
//  - Type: sel = type_en_i[lfsr.type] ? lfsr.type : ADD.
//  - Encoding: {f7, op_b, op_a, f3, 5'h00, 7'h33}.
//    ADD 00/0, SUB 20/0, XOR 00/4, OR 00/6, AND 00/7, MUL 01/0, MULH 01/1, DIV 01/4 (f7 hex/f3).
//  - Widths: cnt_q compare unsigned CntW; burst_left_q is $clog2(MaxBurst)+1 bits, never wraps.
// CONFIGURATION
//  BRQ_DUMMY_PERF_CNT_EN defined:
//    adds port dummy_count_o (out, 32): count of handshaked dummies (INSERT & id_in_ready_i & !flush_i);
//    reset 0, saturates at 32'hFFFF_FFFF.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - brq_dummy_pkg: dummy_type_e (3-bit enum, 8 ops above), f7/f3 encoding constants,
//    lfsr_field_t layout helper.
//  - Sub-module brq_ifu_dummy_enc: combinational type-enable fallback + R-type encoding.
//  - prim_lfsr instantiated directly.
// TESTING
//  1. en=0, 200 accepted fetches -> insert_o never 1; LFSR state unchanged.
//  2. en=1, mask=3'b000, burst_en=0 -> insert_o rises after exactly threshold+1 (1..4) accepts;
//     data[11:0]=12'h033 every time.
//  3. burst_en=1, MaxBurst=4 -> exactly lfsr.burst+1 consecutive dummies.
//     id_in_ready_i low 3 cycles mid-burst -> data held, burst_left_q unchanged.
//  4. type_en=8'h01 over 1000 dummies -> all f7=0,f3=0 (ADD).
//     type_en=8'h80 -> only DIV or ADD.
//  5. flush_i in INSERT with burst_left_q=3 -> next cycle insert_o=0, COUNT, cnt_q=0.
//  6. rst_ni low mid-burst -> insert_o=0 immediately; post-reset IDLE, seed_q=0.
//     Seed strobe with seed_i=32'hA5A5_0001 -> LFSR equals the model.

Source files
------------

// File: rtl/brq_dummy_pkg.sv
// Shared types and encoding constants for the IF-stage dummy instruction inserter.
// Holds the op-type enum, FSM states, R-type funct fields and the LFSR field layout.
package brq_dummy_pkg;

    typedef enum logic [2:0] {
        DUMMY_ADD  = 3'd0,
        DUMMY_SUB  = 3'd1,
        DUMMY_XOR  = 3'd2,
        DUMMY_OR   = 3'd3,
        DUMMY_AND  = 3'd4,
        DUMMY_MUL  = 3'd5,
        DUMMY_MULH = 3'd6,
        DUMMY_DIV  = 3'd7
    } dummy_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_INSERT = 2'd2
    } dummy_state_e;

    localparam logic [6:0] OpcodeOp   = 7'h33;
    localparam logic [4:0] RdZero     = 5'h00;

    localparam logic [6:0] F7Base     = 7'h00;
    localparam logic [6:0] F7Alt      = 7'h20;
    localparam logic [6:0] F7MulDiv   = 7'h01;

    localparam logic [2:0] F3AddSub   = 3'd0;
    localparam logic [2:0] F3Mulh     = 3'd1;
    localparam logic [2:0] F3Xor      = 3'd4;
    localparam logic [2:0] F3Or       = 3'd6;
    localparam logic [2:0] F3And      = 3'd7;
    localparam logic [2:0] F3Div      = 3'd4;

    // Width-independent LFSR fields sitting directly above the count field.
    typedef struct packed {
        dummy_type_e typ;
        logic [4:0]  op_b;
        logic [4:0]  op_a;
    } lfsr_field_t;

    localparam int unsigned FieldW = $bits(lfsr_field_t);

    function automatic logic [9:0] dummy_funct(input dummy_type_e t);
        logic [9:0] f;
        unique case (t)
            DUMMY_ADD:  f = {F7Base,   F3AddSub};
            DUMMY_SUB:  f = {F7Alt,    F3AddSub};
            DUMMY_XOR:  f = {F7Base,   F3Xor};
            DUMMY_OR:   f = {F7Base,   F3Or};
            DUMMY_AND:  f = {F7Base,   F3And};
            DUMMY_MUL:  f = {F7MulDiv, F3AddSub};
            DUMMY_MULH: f = {F7MulDiv, F3Mulh};
            DUMMY_DIV:  f = {F7MulDiv, F3Div};
            default:    f = {F7Base,   F3AddSub};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/brq_ifu_dummy_enc.sv
// Dummy op selection and R-type encoding (rd = x0).
// Disabled op types fall back to ADD.
module brq_ifu_dummy_enc
    import brq_dummy_pkg::*;
(
    input  dummy_type_e i_type,
    input  logic [7:0]  i_type_en,
    input  logic [4:0]  i_op_a,
    input  logic [4:0]  i_op_b,
    output logic [31:0] o_instr
);

    dummy_type_e w_sel;
    logic [9:0]  w_funct;

    always_comb begin
        w_sel   = i_type_en[i_type] ? i_type : DUMMY_ADD;
        w_funct = dummy_funct(w_sel);
        o_instr = {w_funct[9:3], i_op_b, i_op_a, w_funct[2:0], RdZero, OpcodeOp};
    end

endmodule

// File: rtl/prim_lfsr.sv
// Galois LFSR with seed load; seed load takes priority over stepping.
// An all-zero state recovers to DefaultSeed on the next step instead of locking up.
module prim_lfsr #(
    parameter int unsigned        LfsrDw      = 32,
    parameter logic [LfsrDw-1:0]  DefaultSeed = {LfsrDw{1'b1}},
    parameter logic [LfsrDw-1:0]  Taps        = {1'b1, {(LfsrDw-1){1'b0}}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_lfsr_en,
    input  logic              i_seed_en,
    input  logic [LfsrDw-1:0] i_seed,
    output logic [LfsrDw-1:0] o_state
);

    logic [LfsrDw-1:0] r_state;
    logic [LfsrDw-1:0] w_next;

    always_comb begin
        w_next = r_state;
        if (i_seed_en) begin
            w_next = i_seed;
        end else if (i_lfsr_en) begin
            if (r_state == '0) begin
                w_next = DefaultSeed;
            end else begin
                w_next = (r_state >> 1) ^ ({LfsrDw{r_state[0]}} & Taps);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= DefaultSeed;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/brq_ifu_dummy_burst.sv
// IF-stage dummy instruction inserter: random-length real-fetch windows followed by
// bursts of dummy R-type ops. BRQ_DUMMY_PERF_CNT_EN adds a handshaked-dummy counter port.
module brq_ifu_dummy_burst
    import brq_dummy_pkg::*;
#(
    parameter int unsigned CntW     = 5,
    parameter int unsigned MaskW    = 3,
    parameter int unsigned MaxBurst = 4,
    parameter int unsigned LfsrW    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dummy_instr_en_i,
    input  logic [MaskW-1:0] dummy_instr_mask_i,
    input  logic [7:0]       dummy_type_en_i,
    input  logic             dummy_burst_en_i,
    input  logic             dummy_seed_en_i,
    input  logic [31:0]      dummy_seed_i,
    input  logic             fetch_valid_i,
    input  logic             id_in_ready_i,
    input  logic             flush_i,
    output logic             insert_dummy_instr_o,
    output logic [31:0]      dummy_instr_data_o
`ifdef BRQ_DUMMY_PERF_CNT_EN
    ,
    output logic [31:0]      dummy_count_o
`endif
);

    localparam int unsigned BurstW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
    localparam int unsigned BlW    = $clog2(MaxBurst) + 1;
    localparam logic [LfsrW-1:0] LfsrSeed = LfsrW'(32'h6D3A_91C5);
    localparam logic [LfsrW-1:0] LfsrTaps = {1'b1, (LfsrW-1)'(32'h0020_0003)};

    dummy_state_e     r_state;
    logic [CntW-1:0]  r_cnt_q;
    logic [BlW-1:0]   r_burst_left_q;
    logic [31:0]      r_seed_q;

    logic [LfsrW-1:0] w_lfsr_state;
    logic [31:0]      w_seed_next;
    logic             w_lfsr_step;
    logic [CntW-1:0]  w_keep;
    logic [CntW-1:0]  w_threshold;
    lfsr_field_t      w_fields;
    logic [BlW-1:0]   w_burst_len;
    logic             w_accept;

    assign w_seed_next = r_seed_q ^ dummy_seed_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seed_q <= '0;
        end else if (dummy_seed_en_i) begin
            r_seed_q <= w_seed_next;
        end
    end

    // Steps on every consumed dummy, and once more when a burst is flushed so no op repeats.
    assign w_lfsr_step = (r_state == ST_INSERT) & dummy_instr_en_i & (flush_i | id_in_ready_i);

    prim_lfsr #(
        .LfsrDw      (LfsrW),
        .DefaultSeed (LfsrSeed),
        .Taps        (LfsrTaps)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_lfsr_en (w_lfsr_step),
        .i_seed_en (dummy_seed_en_i),
        .i_seed    (LfsrW'(w_seed_next)),
        .o_state   (w_lfsr_state)
    );

    always_comb begin
        w_keep = '1;
        w_keep[CntW-1 -: MaskW] = dummy_instr_mask_i;
    end

    assign w_threshold = w_lfsr_state[CntW-1:0] & w_keep;
    assign w_fields    = w_lfsr_state[CntW +: FieldW];

    generate
        if (MaxBurst > 1) begin : g_burst
            assign w_burst_len = BlW'(w_lfsr_state[CntW + FieldW +: BurstW]) + BlW'(1);
        end else begin : g_single
            assign w_burst_len = BlW'(1);
        end
    endgenerate

    assign insert_dummy_instr_o = (r_state == ST_INSERT) & dummy_instr_en_i;
    assign w_accept = fetch_valid_i & id_in_ready_i & ~insert_dummy_instr_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_cnt_q        <= '0;
            r_burst_left_q <= '0;
        end else if (!dummy_instr_en_i) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state <= ST_COUNT;
                    r_cnt_q <= '0;
                end
                ST_COUNT: begin
                    if (flush_i) begin
                        r_cnt_q <= '0;
                    end else if (w_accept) begin
                        // >= rather than == so a mask narrowed mid-window still terminates it.
                        if (r_cnt_q >= w_threshold) begin
                            r_state        <= ST_INSERT;
                            r_cnt_q        <= '0;
                            r_burst_left_q <= dummy_burst_en_i ? w_burst_len : BlW'(1);
                        end else begin
                            r_cnt_q <= r_cnt_q + CntW'(1);
                        end
                    end
                end
                ST_INSERT: begin
                    if (flush_i) begin
                        r_state        <= ST_COUNT;
                        r_cnt_q        <= '0;
                        r_burst_left_q <= '0;
                    end else if (id_in_ready_i) begin
                        r_burst_left_q <= r_burst_left_q - BlW'(1);
                        if (r_burst_left_q == BlW'(1)) begin
                            r_state <= ST_COUNT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    brq_ifu_dummy_enc u_enc (
        .i_type    (w_fields.typ),
        .i_type_en (dummy_type_en_i),
        .i_op_a    (w_fields.op_a),
        .i_op_b    (w_fields.op_b),
        .o_instr   (dummy_instr_data_o)
    );

`ifdef BRQ_DUMMY_PERF_CNT_EN
    logic [31:0] r_dummy_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dummy_count <= '0;
        end else if (insert_dummy_instr_o & id_in_ready_i & ~flush_i & (r_dummy_count != '1)) begin
            r_dummy_count <= r_dummy_count + 32'd1;
        end
    end

    assign dummy_count_o = r_dummy_count;
`endif

endmodule

// File: tb/tb_brq_ifu_dummy_burst.sv
// Directed bench for brq_ifu_dummy_burst with a cycle model and a dummy-data scoreboard.
module tb_brq_ifu_dummy_burst;
    import brq_dummy_pkg::*;

    localparam logic [31:0] LFSR_RST = 32'h6D3A_91C5;
    localparam logic [31:0] TAPS     = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mask = 3'b000;
    logic [7:0]  type_en = 8'hFF;
    logic        burst_en = 1'b0;
    logic        seed_en = 1'b0;
    logic [31:0] seed = '0;
    logic        fv = 1'b0;
    logic        rdy = 1'b0;
    logic        fl = 1'b0;
    logic        ins;
    logic [31:0] data;
`ifdef BRQ_DUMMY_PERF_CNT_EN
    logic [31:0] dcount;
`endif

    always #5 clk = ~clk;

    brq_ifu_dummy_burst #(.CntW(5), .MaskW(3), .MaxBurst(4), .LfsrW(32)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .dummy_instr_en_i     (en),
        .dummy_instr_mask_i   (mask),
        .dummy_type_en_i      (type_en),
        .dummy_burst_en_i     (burst_en),
        .dummy_seed_en_i      (seed_en),
        .dummy_seed_i         (seed),
        .fetch_valid_i        (fv),
        .id_in_ready_i        (rdy),
        .flush_i              (fl),
        .insert_dummy_instr_o (ins),
        .dummy_instr_data_o   (data)
`ifdef BRQ_DUMMY_PERF_CNT_EN
        ,
        .dummy_count_o        (dcount)
`endif
    );

    int checks = 0;
    int errors = 0;

    dummy_state_e m_st;
    logic [4:0]   m_cnt;
    logic [2:0]   m_bl;
    logic [31:0]  m_lfsr;
    logic [31:0]  m_seedq;
    logic [31:0]  m_dc;
    logic [31:0]  sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        if (s == 32'd0) return LFSR_RST;
        return (s >> 1) ^ (s[0] ? TAPS : 32'd0);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] s, input logic [7:0] ten);
        logic [2:0] t;
        logic [9:0] ff;
        t = s[17:15];
        if (!ten[t]) t = 3'd0;
        case (t)
            3'd0: ff = {7'h00, 3'd0};
            3'd1: ff = {7'h20, 3'd0};
            3'd2: ff = {7'h00, 3'd4};
            3'd3: ff = {7'h00, 3'd6};
            3'd4: ff = {7'h00, 3'd7};
            3'd5: ff = {7'h01, 3'd0};
            3'd6: ff = {7'h01, 3'd1};
            default: ff = {7'h01, 3'd4};
        endcase
        return {ff[9:3], s[14:10], s[9:5], ff[2:0], 5'd0, 7'h33};
    endfunction

    task automatic m_reset();
        m_st    = ST_IDLE;
        m_cnt   = '0;
        m_bl    = '0;
        m_seedq = '0;
        m_lfsr  = LFSR_RST;
        m_dc    = '0;
        sb_q.delete();
    endtask

    task automatic model_update();
        logic        step;
        logic [4:0]  thr;
        logic [31:0] nl;
        step = (m_st == ST_INSERT) && en && (fl || rdy);
        thr  = m_lfsr[4:0] & {mask, 2'b11};
        nl   = m_lfsr;
        if (m_st == ST_INSERT && en && rdy && !fl) m_dc++;
        if (seed_en) begin
            m_seedq = m_seedq ^ seed;
            nl = m_seedq;
        end else if (step) begin
            nl = lfsr_next(m_lfsr);
        end
        if (!en) begin
            m_st = ST_IDLE;
        end else begin
            case (m_st)
                ST_IDLE: begin
                    m_st = ST_COUNT;
                    m_cnt = '0;
                end
                ST_COUNT: begin
                    if (fl) m_cnt = '0;
                    else if (fv && rdy) begin
                        if (m_cnt >= thr) begin
                            m_st = ST_INSERT;
                            m_cnt = '0;
                            m_bl = burst_en ? ({1'b0, m_lfsr[19:18]} + 3'd1) : 3'd1;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
                default: begin
                    if (fl) begin
                        m_st = ST_COUNT;
                        m_cnt = '0;
                        m_bl = '0;
                    end else if (rdy) begin
                        if (m_bl == 3'd1) m_st = ST_COUNT;
                        m_bl--;
                    end
                end
            endcase
        end
        m_lfsr = nl;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic tick();
        logic        exp_ins;
        logic [31:0] exp_d;
        #1;
        exp_ins = (m_st == ST_INSERT) && en;
        if (exp_ins) sb_q.push_back(exp_instr(m_lfsr, type_en));
        chk("insert_o", {31'd0, ins}, {31'd0, exp_ins});
        chk("cnt_q", {27'd0, dut.r_cnt_q}, {27'd0, m_cnt});
        chk("burst_left_q", {29'd0, dut.r_burst_left_q}, {29'd0, m_bl});
        chk("lfsr_state", dut.u_lfsr.r_state, m_lfsr);
`ifdef BRQ_DUMMY_PERF_CNT_EN
        chk("dummy_count", dcount, m_dc);
`endif
        if (ins === 1'b1) begin
            if (sb_q.size() > 0) exp_d = sb_q.pop_front();
            else exp_d = 32'hxxxx_xxxx;
            chk("dummy_data", data, exp_d);
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run_to_insert();
        for (int k = 0; k < 300 && m_st != ST_INSERT; k++) begin
            fv = 1'b1;
            rdy = 1'b1;
            tick();
        end
        #1;
        chk("reach_insert", {31'd0, ins}, 32'd1);
    endtask

    task automatic seed_to(input logic [31:0] v);
        fv = 1'b0;
        rdy = 1'b0;
        seed = v ^ m_seedq;
        seed_en = 1'b1;
        tick();
        seed_en = 1'b0;
        chk("seed_lfsr", dut.u_lfsr.r_state, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nacc;
        int win;
        int n;
        int explen;
        int cnt;
        logic stalled;
        logic [9:0] f;

        m_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_insert", {31'd0, ins}, 32'd0);
        chk("rst_state", {30'd0, dut.r_state}, {30'd0, ST_IDLE});
        chk("rst_seed", dut.r_seed_q, 32'd0);
        chk("rst_lfsr", dut.u_lfsr.r_state, LFSR_RST);

        // Disabled: accepted fetches never trigger an insert and the LFSR is idle.
        en = 1'b0;
        fv = 1'b1;
        rdy = 1'b1;
        repeat (200) tick();
        chk("t1_lfsr_unchanged", dut.u_lfsr.r_state, LFSR_RST);

        // Single dummies, mask 0: window of threshold+1 accepts.
        en = 1'b1;
        mask = 3'b000;
        burst_en = 1'b0;
        fv = 1'b0;
        tick();
        for (int w = 0; w < 6; w++) begin
            nacc = 0;
            win = int'(m_lfsr[4:0] & 5'b00011) + 1;
            for (int k = 0; k < 200 && m_st != ST_INSERT; k++) begin
                fv = 1'($urandom_range(0, 1));
                rdy = ($urandom_range(0, 3) != 0);
                if (fv && rdy) nacc++;
                tick();
            end
            chk("t2_window", nacc, win);
            fv = 1'b1;
            rdy = 1'b1;
            #1;
            chk("t2_low12", {20'd0, data[11:0]}, 32'h0000_0033);
            tick();
        end

        // Bursts with a 3-cycle ready stall in the middle.
        burst_en = 1'b1;
        mask = 3'b001;
        seed_to(32'h0008_0000);
        for (int b = 0; b < 5; b++) begin
            run_to_insert();
            explen = int'(m_bl);
            n = 0;
            stalled = 1'b0;
            for (int k = 0; k < 40 && m_st == ST_INSERT; k++) begin
                if (!stalled && n == explen / 2 && explen >= 2) begin
                    rdy = 1'b0;
                    fv = 1'b1;
                    repeat (3) begin
                        tick();
                        chk("t3_bl_hold", {29'd0, dut.r_burst_left_q}, explen - n);
                    end
                    stalled = 1'b1;
                end
                rdy = 1'b1;
                fv = 1'b1;
                tick();
                n++;
            end
            chk("t3_burst_len", n, explen);
        end

        // Type enable fallback.
        type_en = 8'h01;
        mask = 3'b000;
        cnt = 0;
        for (int k = 0; k < 8000 && cnt < 1000; k++) begin
            fv = 1'b1;
            rdy = 1'b1;
            #1;
            if (ins === 1'b1) begin
                chk("t4_add_only", {22'd0, data[31:25], data[14:12]}, 32'd0);
                cnt++;
            end
            tick();
        end
        chk("t4_add_count", cnt, 1000);
        type_en = 8'h80;
        cnt = 0;
        for (int k = 0; k < 2000 && cnt < 200; k++) begin
            fv = 1'b1;
            rdy = 1'b1;
            #1;
            if (ins === 1'b1) begin
                f = {data[31:25], data[14:12]};
                chk("t4_div_or_add", {31'd0, (f == {7'h01, 3'd4}) || (f == 10'd0)}, 32'd1);
                cnt++;
            end
            tick();
        end
        chk("t4_div_count", cnt, 200);

        // Flush mid-burst with three dummies left.
        type_en = 8'hFF;
        for (int k = 0; k < 10 && m_st == ST_INSERT; k++) begin
            rdy = 1'b1;
            tick();
        end
        seed_to(32'h000F_8820);
        run_to_insert();
        chk("t5_burst4", {29'd0, dut.r_burst_left_q}, 32'd4);
        fv = 1'b0;
        rdy = 1'b1;
        tick();
        chk("t5_bl3", {29'd0, dut.r_burst_left_q}, 32'd3);
        fl = 1'b1;
        tick();
        fl = 1'b0;
        rdy = 1'b0;
        #1;
        chk("t5_ins_low", {31'd0, ins}, 32'd0);
        chk("t5_state", {30'd0, dut.r_state}, {30'd0, ST_COUNT});
        chk("t5_cnt", {27'd0, dut.r_cnt_q}, 32'd0);
        tick();

        // Flush while counting clears the count.
        mask = 3'b111;
        seed_to(32'h0000_001F);
        fv = 1'b1;
        rdy = 1'b1;
        repeat (3) tick();
        chk("t5_cnt_pre_flush", {27'd0, dut.r_cnt_q}, 32'd3);
        fl = 1'b1;
        tick();
        fl = 1'b0;
        chk("t5_cnt_flushed", {27'd0, dut.r_cnt_q}, 32'd0);

        // Asynchronous reset in the middle of a burst, then reseed.
        mask = 3'b000;
        seed_to(32'h000C_0000);
        run_to_insert();
        fv = 1'b0;
        rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ins_async", {31'd0, ins}, 32'd0);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_state_idle", {30'd0, dut.r_state}, {30'd0, ST_IDLE});
        chk("t6_seed_zero", dut.r_seed_q, 32'd0);
        seed = 32'hA5A5_0001;
        seed_en = 1'b1;
        tick();
        seed_en = 1'b0;
        chk("t6_seed_lfsr", dut.u_lfsr.r_state, 32'hA5A5_0001);
        chk("t6_seed_q", dut.r_seed_q, 32'hA5A5_0001);
        for (int k = 0; k < 60; k++) begin
            fv = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
